// File: rtl/approx_log_multiplier_pipe_if.sv
// Operand/result stream bundle for approx_log_multiplier_pipe.
//   in_valid/in_ready : operand pair handshake (a, b)
//   out_valid/out_ready : result handshake (result, 2W bits signed)
//   exact (only with LOGMUL_EXACT_MODE_EN) : request the true product for this item
// slave modport is the multiplier's view; master is the producer/consumer's view.
interface approx_log_multiplier_pipe_if #(
  parameter int W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*W-1:0] result;
`ifdef LOGMUL_EXACT_MODE_EN
  logic                  exact;
`endif

  modport slave (
`ifdef LOGMUL_EXACT_MODE_EN
    input  exact,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
`ifdef LOGMUL_EXACT_MODE_EN
    output exact,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/approx_log_multiplier_pipe.sv
// Pipelined signed approximate multiplier (Mitchell log/antilog with dynamic
// truncation). Three registered stages: operand log, log sum, antilog/sign.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (clears stage valids and result)
//   bus   : approx_log_multiplier_pipe_if.slave (operand in / result out streams)
// Optional macro LOGMUL_EXACT_MODE_EN adds bus.exact; items flagged exact get
// the true product a*b with identical latency and handshake.
module approx_log_multiplier_pipe #(
  parameter  int DATA_W = 8,
  parameter  int W      = DATA_W,
  parameter  int T      = 6,
  localparam int KW     = $clog2(W),
  localparam int LW     = KW + T - 1
) (
  input logic                        clk,
  input logic                        rst_n,
  approx_log_multiplier_pipe_if.slave bus
);

  function automatic logic [W-1:0] abs_val(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = v;
    // -2^(W-1) wraps to 2^(W-1), which is representable as unsigned
    return u[W-1] ? (~u + 1'b1) : u;
  endfunction

  // {k, x_t}: leading-one index and truncated fraction with forced LSB
  function automatic logic [LW-1:0] mitchell_log(input logic [W-1:0] m);
    logic [KW-1:0] k;
    logic [T-2:0]  xt;
    k = '0;
    for (int i = 0; i < W; i++) begin
      if (m[i]) k = KW'(i);
    end
    xt    = '0;
    xt[0] = 1'b1;
    for (int i = 0; i < T - 2; i++) begin
      if (int'(k) > i) xt[T-2-i] = m[int'(k)-1-i];
    end
    return {k, xt};
  endfunction

  // (({1,F}) << K) >> (T-1), split by shift direction so no bits are lost
  function automatic logic [2*W-1:0] antilog(input logic [LW:0] l);
    logic [KW:0]    kk;
    logic [2*W-1:0] m;
    kk = l[LW:T-1];
    m  = {{(2*W-T){1'b0}}, 1'b1, l[T-2:0]};
    if (int'(kk) >= T - 1) return m << (int'(kk) - (T - 1));
    else                   return m >> ((T - 1) - int'(kk));
  endfunction

  function automatic logic signed [2*W-1:0] apply_sign(input logic [2*W-1:0] p,
                                                      input logic neg);
    return neg ? signed'(~p + 1'b1) : signed'(p);
  endfunction

  logic                  advance;

  logic                  vld_p1_q, vld_p1_d;
  logic                  zero_p1_q, zero_p1_d;
  logic                  sign_p1_q, sign_p1_d;
  logic [LW-1:0]         loga_p1_q, loga_p1_d;
  logic [LW-1:0]         logb_p1_q, logb_p1_d;

  logic                  vld_p2_q, vld_p2_d;
  logic                  zero_p2_q, zero_p2_d;
  logic                  sign_p2_q, sign_p2_d;
  logic [LW:0]           lsum_p2_q, lsum_p2_d;

  logic                  vld_p3_q, vld_p3_d;
  logic signed [2*W-1:0] res_p3_q, res_p3_d;

`ifdef LOGMUL_EXACT_MODE_EN
  logic                  exact_p1_q, exact_p1_d;
  logic signed [W-1:0]   a_p1_q, a_p1_d;
  logic signed [W-1:0]   b_p1_q, b_p1_d;
  logic                  exact_p2_q, exact_p2_d;
  logic signed [W-1:0]   a_p2_q, a_p2_d;
  logic signed [W-1:0]   b_p2_q, b_p2_d;
  logic signed [2*W-1:0] ax, bx;
`endif

  // Whole pipe moves together; the output slot frees when taken or empty
  always_comb begin
    advance       = bus.out_ready | ~vld_p3_q;
    bus.in_ready  = advance;
    bus.out_valid = vld_p3_q;
    bus.result    = res_p3_q;
  end

  // Stage 1: sign, zero detect, operand logs
  always_comb begin
    vld_p1_d  = bus.in_valid;
    zero_p1_d = (bus.a == '0) | (bus.b == '0);
    sign_p1_d = bus.a[W-1] ^ bus.b[W-1];
    loga_p1_d = mitchell_log(abs_val(bus.a));
    logb_p1_d = mitchell_log(abs_val(bus.b));
`ifdef LOGMUL_EXACT_MODE_EN
    exact_p1_d = bus.exact;
    a_p1_d     = bus.a;
    b_p1_d     = bus.b;
`endif
  end

  // Stage 2: log sum (one bit wider, cannot overflow)
  always_comb begin
    vld_p2_d  = vld_p1_q;
    zero_p2_d = zero_p1_q;
    sign_p2_d = sign_p1_q;
    lsum_p2_d = {1'b0, loga_p1_q} + {1'b0, logb_p1_q};
`ifdef LOGMUL_EXACT_MODE_EN
    exact_p2_d = exact_p1_q;
    a_p2_d     = a_p1_q;
    b_p2_d     = b_p1_q;
`endif
  end

  // Stage 3: antilog and sign restore
  always_comb begin
    vld_p3_d = vld_p2_q;
    res_p3_d = zero_p2_q ? '0 : apply_sign(antilog(lsum_p2_q), sign_p2_q);
`ifdef LOGMUL_EXACT_MODE_EN
    ax = a_p2_q;
    bx = b_p2_q;
    if (exact_p2_q) res_p3_d = ax * bx;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      res_p3_q <= '0;
    end else if (advance) begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      res_p3_q <= res_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      zero_p1_q <= zero_p1_d;
      sign_p1_q <= sign_p1_d;
      loga_p1_q <= loga_p1_d;
      logb_p1_q <= logb_p1_d;
      zero_p2_q <= zero_p2_d;
      sign_p2_q <= sign_p2_d;
      lsum_p2_q <= lsum_p2_d;
`ifdef LOGMUL_EXACT_MODE_EN
      exact_p1_q <= exact_p1_d;
      a_p1_q     <= a_p1_d;
      b_p1_q     <= b_p1_d;
      exact_p2_q <= exact_p2_d;
      a_p2_q     <= a_p2_d;
      b_p2_q     <= b_p2_d;
`endif
    end
  end

endmodule

// File: tb/tb_approx_log_multiplier_pipe.sv
// Self-checking bench for approx_log_multiplier_pipe (W=8, T=6).
module tb_approx_log_multiplier_pipe;
  localparam int W = 8;
  localparam int T = 6;

  typedef struct {
    logic signed [2*W-1:0] v;
    int                    c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  approx_log_multiplier_pipe_if #(.W(W)) bus ();

  approx_log_multiplier_pipe #(.W(W), .T(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   chk_lat = 1'b1;
  bit   use_lit = 1'b0;
  bit   cur_ex = 1'b0;
  logic signed [2*W-1:0] lit_val = '0;
  logic signed [2*W-1:0] held;
  exp_t expq[$];

  // Mitchell log of a positive magnitude: k*2^(T-1) + truncated fraction
  function automatic longint mlog(input longint v);
    longint k, frac, aligned, top;
    k = 0;
    while ((v >> (k + 1)) != 0) k++;
    frac    = v - (longint'(1) << k);
    aligned = frac << (W - 1 - k);
    top     = aligned >> (W - T + 1);
    return k * (longint'(1) << (T - 1)) + top * 2 + 1;
  endfunction

  function automatic longint model(input int a, input int b, input bit ex);
    longint l, kk, f, p;
    bit neg;
    if (ex) return longint'(a) * longint'(b);
    if (a == 0 || b == 0) return 0;
    neg = (a < 0) ^ (b < 0);
    l  = mlog(a < 0 ? -a : a) + mlog(b < 0 ? -b : b);
    kk = l >> (T - 1);
    f  = l % (longint'(1) << (T - 1));
    p  = (((longint'(1) << (T - 1)) + f) << kk) >> (T - 1);
    return neg ? -p : p;
  endfunction

  // One clock: score the output transfer and record the input transfer
  // as seen just before the edge, then advance past the edge.
  task automatic tick();
    exp_t e;
    bit   r;
    longint mv;
    #1;
    r = rst_n;
    if (bus.out_valid && bus.out_ready && r) begin
      checks++;
      assert (expq.size() != 0) else begin
        failures++;
        $error("FAIL spurious_output result=%0d expected no output", bus.result);
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        n_out++;
        checks++;
        assert (bus.result === e.v) else begin
          failures++;
          $error("FAIL result got=%0d exp=%0d", bus.result, e.v);
        end
        if (chk_lat) begin
          checks++;
          assert (cyc - e.c === 3) else begin
            failures++;
            $error("FAIL latency got=%0d exp=3", cyc - e.c);
          end
        end
      end
    end
    if (bus.in_valid && bus.in_ready && r) begin
      mv  = model(int'(bus.a), int'(bus.b), cur_ex);
      e.v = use_lit ? lit_val : (2*W)'(mv);
      e.c = cyc;
      expq.push_back(e);
    end
    @(posedge clk);
    cyc++;
    if (!r) expq.delete();
    #1;
  endtask

  task automatic drive(input int a, input int b, input bit ex);
    bus.in_valid = 1'b1;
    bus.a        = W'(a);
    bus.b        = W'(b);
    cur_ex       = ex;
`ifdef LOGMUL_EXACT_MODE_EN
    bus.exact    = ex;
`endif
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    cur_ex       = 1'b0;
`ifdef LOGMUL_EXACT_MODE_EN
    bus.exact    = 1'b0;
`endif
  endtask

  task automatic single(input int a, input int b, input bit ex, input int expv);
    use_lit = 1'b1;
    lit_val = (2*W)'(expv);
    drive(a, b, ex);
    tick();
    idle();
    use_lit = 1'b0;
    repeat (4) tick();
  endtask

  task automatic chk(input string tag, input longint got, input longint expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
`ifdef LOGMUL_EXACT_MODE_EN
    bus.exact     = 1'b0;
`endif
    rst_n = 1'b0;

    // reset for two cycles
    repeat (2) begin
      tick();
      chk("reset_out_valid", longint'(bus.out_valid), 0);
      chk("reset_result", longint'(bus.result), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_reset", longint'(bus.in_ready), 1);

    // directed single items with spec-given values
    single(3, 5, 1'b0, 14);
    single(-3, 5, 1'b0, -14);
    single(0, 77, 1'b0, 0);
    single(-128, -128, 1'b0, 17408);
    single(127, 127, 1'b0, 15872);
    chk("single_outputs", longint'(n_out), 5);

    // 20 back-to-back random pairs
    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      drive(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b0);
      tick();
    end
    idle();
    repeat (4) tick();
    chk("stream_outputs", longint'(n_out), 20);

    // stall with three items in flight
    n_out = 0;
    for (int i = 0; i < 3; i++) begin
      drive(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b0);
      tick();
    end
    chk_lat = 1'b0;
    bus.out_ready = 1'b0;
    drive(-77, 91, 1'b0);
    #1;
    held = bus.result;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", longint'(bus.in_ready), 0);
      chk("stall_out_valid", longint'(bus.out_valid), 1);
      chk("stall_result_held", longint'(bus.result), longint'(held));
    end
    bus.out_ready = 1'b1;
    tick();
    idle();
    repeat (6) tick();
    chk("stall_outputs", longint'(n_out), 4);
    chk_lat = 1'b1;

    // reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      drive(int'($urandom_range(1, 127)), int'($urandom_range(1, 127)), 1'b0);
      tick();
    end
    idle();
    rst_n = 1'b0;
    tick();
    chk("midreset_out_valid", longint'(bus.out_valid), 0);
    rst_n = 1'b1;
    n_out = 0;
    repeat (6) tick();
    chk("midreset_no_outputs", longint'(n_out), 0);

`ifdef LOGMUL_EXACT_MODE_EN
    single(3, 5, 1'b1, 15);
    single(3, 5, 1'b0, 14);
    n_out = 0;
    for (int i = 0; i < 10; i++) begin
      drive(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            1'($urandom_range(0, 1)));
      tick();
    end
    idle();
    repeat (4) tick();
    chk("exact_mix_outputs", longint'(n_out), 10);
`endif

    chk("queue_drained", longint'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/approx_log_multiplier_pipe.md
Name: approx_log_multiplier_pipe

Overview:
- Parametrised, pipelined successor to the combinational 8-bit approximate log multiplier.
- Signed W-bit × W-bit multiply via Mitchell log/antilog with dynamic truncation to T fraction-related bits.
- 3-stage pipeline with valid/ready handshake; sits between operand stream source and accumulator/consumer in the approximate MAC datapath.

Parameters:
- W, 8, operand width (signed two's complement), W ≥ 4.
- T, 6, truncation width: x_t is T-1 bits; 3 ≤ T ≤ W.
- KW, $clog2(W), characteristic width (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  W  signed operand A.
- b  in  W  signed operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  2W  signed approximate product.

Behaviour:
- Reset: on rising clk with rst_n=0, all stage valid flags clear; out_valid=0, result=0; in_ready=1 on the following cycle. Reset mid-operation discards all in-flight products, with no output for them.
- Handshake: advance = out_ready | ~out_valid; in_ready = advance. Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready. Whole pipe stalls together when advance=0; all stage registers hold; result stable while out_valid & ~out_ready.
- Latency: 3 cycles, accept edge to out_valid. Throughput 1/cycle with out_ready=1. Bubbles propagate as valid=0.
- S1 (registered): zero_flag = (a==0)|(b==0); sign = a[W-1]^b[W-1]. abs in W-bit unsigned; -2^(W-1) maps to 2^(W-1). k = leading-one index. x = bits below leading one, left-aligned into W-1 bits. Dynamic truncation: x_t = {x[W-2 : W-T+1], 1'b1} (T-1 bits).
- S2 (registered): log = {k, x_t}; L = log_A + log_B, width KW+T, no overflow.
- S3 (registered): K = L[KW+T-1 : T-1], F = L[T-2:0]. M = {1'b1, F}; P = (M << K) >> (T-1), floor truncation. result = zero_flag ? 0 : (sign ? -P : P).
- P < 2^(2W-1) for all inputs; no saturation logic required.
- Simultaneous in/out transfer on the same edge is legal and must not lose or duplicate data.

Optional Feature:
- Macro LOGMUL_EXACT_MODE_EN.
- Defined: adds input port exact (1 bit), captured with the operands and carried down the pipe. When exact=1, S3 outputs the true signed product a*b for that item; latency and handshake are unchanged. exact=0 behaves as the approximate path.
- Undefined: no exact port and no exact-multiplier hardware; only the approximate path exists.

Test Plan (W=8, T=6, out_ready=1 unless stated):
- Reset with rst_n=0 for 2 cycles, then release -> out_valid=0, result=0 during reset; in_ready=1 after release.
- Single-item products: a=3,b=5 -> result=14 exactly 3 cycles after accept; a=-3,b=5 -> -14; a=0,b=77 -> 0; a=-128,b=-128 -> 17408; a=127,b=127 -> 15872.
- Streaming: 20 back-to-back random pairs -> 20 results in order, one per cycle, each matching the bit-exact software model.
- Stall: 3 items in flight, drop out_ready for 5 cycles -> in_ready=0, out_valid=1, result held constant; resumes in order with no loss or duplicate.
- Reset mid-stream: assert rst_n=0 with 3 items in flight -> out_valid=0 next cycle; none of those items ever appear at the output.
- With LOGMUL_EXACT_MODE_EN: a=3,b=5,exact=1 -> 15; the next item a=3,b=5,exact=0 -> 14.
